// File: rtl/ofifo_pkg.sv
//------------------------------------------------------------------------------
// ofifo_pkg : shared defaults and pointer-width helper for the output FIFO
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ofifo_pkg;

  localparam int OFIFO_COL     = 8;
  localparam int OFIFO_PSUM_BW = 16;
  localparam int OFIFO_DEPTH   = 64;
  localparam int OFIFO_OVF_W   = 16;

  // Pointer width for a power-of-two depth; never below one bit.
  function automatic int ptr_w(input int d);
    return (d <= 2) ? 1 : $clog2(d);
  endfunction

endpackage : ofifo_pkg

`default_nettype wire

// File: rtl/ofifo_lane.sv
//------------------------------------------------------------------------------
// ofifo_lane : one column of the output FIFO (storage, pointers, occupancy)
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ofifo_lane
  import ofifo_pkg::*;
#(
  parameter int psum_bw = OFIFO_PSUM_BW,
  parameter int depth   = OFIFO_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_wr,
  input  logic [psum_bw-1:0] i_din,
  input  logic               i_pop,
  output logic [psum_bw-1:0] o_head,
  output logic               o_full,
  output logic               o_empty
);

  localparam int                 c_PTR_W   = ptr_w(depth);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
  localparam logic [c_PTR_W:0]   c_CNT_ONE = (c_PTR_W + 1)'(1);
  localparam logic [c_PTR_W:0]   c_DEPTH   = (c_PTR_W + 1)'(depth);

  logic [psum_bw-1:0] r_mem [depth];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_PTR_W:0]   r_count;
  logic               w_accept;

  assign o_full   = (r_count == c_DEPTH);
  assign o_empty  = (r_count == '0);
  // Fullness is judged on the registered count, so a same-cycle pop never frees room.
  assign w_accept = i_wr & ~o_full;
  assign o_head   = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wptr] <= i_din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) begin
        r_wptr <= r_wptr + c_PTR_ONE;
      end
      if (i_pop) begin
        r_rptr <= r_rptr + c_PTR_ONE;
      end
      case ({w_accept, i_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : ofifo_lane

`default_nettype wire

// File: rtl/ofifo.sv
//------------------------------------------------------------------------------
// ofifo : multi-lane output FIFO popping whole rows into a registered output.
//         Optional dropped-write counter enabled by OFIFO_OVF_CNT_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ofifo
  import ofifo_pkg::*;
#(
  parameter int col     = OFIFO_COL,
  parameter int psum_bw = OFIFO_PSUM_BW,
  parameter int depth   = OFIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col-1:0]         wr,
  input  logic [col*psum_bw-1:0] in,
  input  logic                   rd,
  output logic [col*psum_bw-1:0] out,
  output logic                   out_valid,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic [OFIFO_OVF_W-1:0] ovf_cnt
);

  logic [col-1:0]         w_full;
  logic [col-1:0]         w_empty;
  logic [col*psum_bw-1:0] w_head;
  logic                   w_pop;
  logic [col*psum_bw-1:0] r_out;
  logic                   r_out_valid;

  generate
    for (genvar gi = 0; gi < col; gi++) begin : g_lane
      ofifo_lane #(
        .psum_bw (psum_bw),
        .depth   (depth)
      ) u_lane (
        .clk     (clk),
        .rst     (reset),
        .i_wr    (wr[gi]),
        .i_din   (in[gi*psum_bw +: psum_bw]),
        .i_pop   (w_pop),
        .o_head  (w_head[gi*psum_bw +: psum_bw]),
        .o_full  (w_full[gi]),
        .o_empty (w_empty[gi])
      );
    end
  endgenerate

  assign o_valid = ~|w_empty;
  assign o_full  = |w_full;
  assign o_ready = ~o_full;
  // A row leaves only when every lane has data; otherwise rd is ignored.
  assign w_pop   = rd & o_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_pop;
      if (w_pop) begin
        r_out <= w_head;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;

`ifdef OFIFO_OVF_CNT_EN
  logic [col-1:0]         w_drop;
  logic [OFIFO_OVF_W:0]   w_ovf_sum;
  logic [OFIFO_OVF_W-1:0] r_ovf_cnt;

  assign w_drop = wr & w_full;

  always_comb begin
    w_ovf_sum = {1'b0, r_ovf_cnt};
    for (int i = 0; i < col; i++) begin
      w_ovf_sum = w_ovf_sum + {{OFIFO_OVF_W{1'b0}}, w_drop[i]};
    end
  end

  // Carry out of the 16-bit sum means the counter saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf_cnt <= '0;
    end else if (w_ovf_sum[OFIFO_OVF_W]) begin
      r_ovf_cnt <= '1;
    end else begin
      r_ovf_cnt <= w_ovf_sum[OFIFO_OVF_W-1:0];
    end
  end

  assign ovf_cnt = r_ovf_cnt;
`else
  assign ovf_cnt = '0;
`endif

endmodule : ofifo

`default_nettype wire

// File: tb/tb_ofifo.sv
//------------------------------------------------------------------------------
// tb_ofifo : directed self-checking bench for ofifo (default parameters)
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ofifo;

  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int DEP = 64;
  localparam int W   = COL * BW;

`ifdef OFIFO_OVF_CNT_EN
  localparam logic [15:0] OVF_EXP = 16'd1;
`else
  localparam logic [15:0] OVF_EXP = 16'd0;
`endif

  logic           clk   = 1'b0;
  logic           reset = 1'b1;
  logic [COL-1:0] wr    = '0;
  logic [W-1:0]   in    = '0;
  logic           rd    = 1'b0;
  logic [W-1:0]   out;
  logic           out_valid;
  logic           o_valid;
  logic           o_full;
  logic           o_ready;
  logic [15:0]    ovf_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int nw;
  int np;
  logic         pop_exp;
  logic [W-1:0] exp_row;
  logic [W-1:0] tmp_row;

  ofifo #(.col(COL), .psum_bw(BW), .depth(DEP)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr        (wr),
    .in        (in),
    .rd        (rd),
    .out       (out),
    .out_valid (out_valid),
    .o_valid   (o_valid),
    .o_full    (o_full),
    .o_ready   (o_ready),
    .ovf_cnt   (ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lane i = 16*c + i
  function automatic logic [W-1:0] row_a(input int c);
    logic [W-1:0] r;
    for (int i = 0; i < COL; i++) r[i*BW +: BW] = 16'(16 * c + i);
    return r;
  endfunction

  // lane 3 = k, other lanes = 0x100 + k
  function automatic logic [W-1:0] row_c(input int k);
    logic [W-1:0] r;
    for (int i = 0; i < COL; i++) r[i*BW +: BW] = (i == 3) ? 16'(k) : 16'(256 + k);
    return r;
  endfunction

  // lane i = (i << 12) | k
  function automatic logic [W-1:0] row_d(input int k);
    logic [W-1:0] r;
    for (int i = 0; i < COL; i++) r[i*BW +: BW] = 16'((i << 12) | (k & 12'hFFF));
    return r;
  endfunction

  initial begin
    // ---- reset state
    #2;
    check("rst_out", out, '0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_o_valid", o_valid, 1'b0);
    check("rst_o_full", o_full, 1'b0);
    check("rst_o_ready", o_ready, 1'b1);
    check("rst_ovf", ovf_cnt, 16'd0);
    tick();
    reset = 1'b0;

    // ---- three full rows, then pop them back in order
    wr = '1;
    for (int c = 0; c < 3; c++) begin
      in = row_a(c);
      tick();
    end
    wr = '0;
    check("t1_o_valid", o_valid, 1'b1);
    rd = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t1_out_valid", out_valid, 1'b1);
      check("t1_out", out, row_a(c));
    end
    check("t1_drained", o_valid, 1'b0);
    tick();
    check("t1_no_pop", out_valid, 1'b0);
    check("t1_out_hold", out, row_a(2));
    rd = 1'b0;

    // ---- partial row: lanes 0-6 only
    wr = 8'h7F;
    in = row_a(5);
    tick();
    wr = '0;
    check("t2_o_valid_lo", o_valid, 1'b0);
    rd = 1'b1;
    tick();
    check("t2_rd_ignored", out_valid, 1'b0);
    check("t2_out_hold", out, row_a(2));
    wr = 8'h80;
    in = row_a(6);
    tick();
    wr = '0;
    check("t2_same_cycle", out_valid, 1'b0);
    check("t2_o_valid_hi", o_valid, 1'b1);
    tick();
    exp_row = row_a(5);
    tmp_row = row_a(6);
    exp_row[W-1 -: BW] = tmp_row[W-1 -: BW];
    check("t2_pop_valid", out_valid, 1'b1);
    check("t2_pop_out", out, exp_row);
    rd = 1'b0;
    check("t2_empty", o_valid, 1'b0);

    // ---- fill lane 3, then a dropped 65th write with rd
    wr = 8'h08;
    for (int k = 0; k < DEP; k++) begin
      in = row_c(k);
      tick();
    end
    check("t3_o_full", o_full, 1'b1);
    check("t3_o_ready", o_ready, 1'b0);
    check("t3_o_valid", o_valid, 1'b0);
    check("t3_ovf_pre", ovf_cnt, 16'd0);
    in = {COL{16'hDEAD}};
    rd = 1'b1;
    tick();
    wr = '0;
    rd = 1'b0;
    check("t3_full_hold", o_full, 1'b1);
    check("t3_ovf", ovf_cnt, OVF_EXP);
    check("t3_no_pop", out_valid, 1'b0);
    wr = 8'hF7;
    for (int k = 0; k < DEP; k++) begin
      in = row_c(k);
      tick();
    end
    wr = '0;
    check("t3_rows_ready", o_valid, 1'b1);
    rd = 1'b1;
    for (int k = 0; k < DEP; k++) begin
      tick();
      check("t3_readback", out, row_c(k));
    end
    rd = 1'b0;
    check("t3_lost_65th", o_valid, 1'b0);
    check("t3_not_full", o_full, 1'b0);

    // ---- 200 rows streamed through, pointers wrap over three laps
    nw = 0;
    np = 0;
    for (int t = 0; t < 210; t++) begin
      wr = (t < 200) ? '1 : '0;
      in = row_d(nw);
      rd = (t >= 10);
      pop_exp = rd && ((nw - np) > 0);
      tick();
      if (t < 200) nw++;
      check("t4_out_valid", out_valid, pop_exp);
      if (pop_exp) begin
        check("t4_out", out, row_d(np));
        np++;
      end
      check("t4_never_full", o_full, 1'b0);
    end
    wr = '0;
    rd = 1'b0;
    check("t4_drained", o_valid, 1'b0);

    // ---- asynchronous reset mid-burst
    wr = '1;
    for (int k = 0; k < 10; k++) begin
      in = row_a(20 + k);
      tick();
    end
    wr = '0;
    rd = 1'b1;
    tick();
    check("t5_pop0", out, row_a(20));
    tick();
    check("t5_pop1", out, row_a(21));
    #3;
    reset = 1'b1;
    #1;
    check("t5_o_valid", o_valid, 1'b0);
    check("t5_out", out, '0);
    check("t5_out_valid", out_valid, 1'b0);
    check("t5_o_ready", o_ready, 1'b1);
    check("t5_ovf", ovf_cnt, 16'd0);
    rd = 1'b0;
    tick();
    reset = 1'b0;
    check("t5_post_empty", o_valid, 1'b0);
    wr = '1;
    in = row_a(40);
    tick();
    in = row_a(41);
    tick();
    wr = '0;
    rd = 1'b1;
    tick();
    check("t5_rb0_valid", out_valid, 1'b1);
    check("t5_rb0", out, row_a(40));
    tick();
    check("t5_rb1", out, row_a(41));
    rd = 1'b0;
    tick();
    check("t5_idle", out_valid, 1'b0);
    check("t5_final_empty", o_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_ofifo

`default_nettype wire
